regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clear_fsm.sv | 56 +++++
 rtl/regfile_mp.sv | 82 ++++++++
 tb/tb_regfile_mp.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } clr_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks registers 1..DEPTH-1 one per cycle, then raises a
// one-cycle done pulse before returning to idle.
import regfile_pkg::*;

module regfile_clear_fsm #(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              ctrl_reset,
   input  logic              i_clear,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_sweep_we,
   output logic [ADDR_W-1:0] o_idx
);

   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

   clr_state_e        r_state;
   logic [ADDR_W-1:0] r_idx;

   // Register 0 is hardwired to zero, so the sweep starts at index 1.
   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         r_state <= ST_IDLE;
         r_idx   <= FIRST_IDX;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_clear) begin
                  r_state <= ST_SWEEP;
                  r_idx   <= FIRST_IDX;
               end
            end
            ST_SWEEP: begin
               if (r_idx == LAST_IDX) begin
                  r_state <= ST_DONE;
                  r_idx   <= FIRST_IDX;
               end else begin
                  r_idx <= r_idx + FIRST_IDX;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy     = (r_state != ST_IDLE);
   assign o_done     = (r_state == ST_DONE);
   assign o_sweep_we = (r_state == ST_SWEEP);
   assign o_idx      = r_idx;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with r0 hardwired to zero and a clear sweep.
// Optional same-cycle write-to-read forwarding under `REGFILE_BYPASS_EN.
import regfile_pkg::*;

module regfile_mp #(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int DEPTH  = DEF_DEPTH,
   parameter  int NUM_RD = 2,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clock,
   input  logic                     ctrl_reset,
   input  logic                     ctrl_writeEnable,
   input  logic [ADDR_W-1:0]        ctrl_writeReg,
   input  logic [DATA_W-1:0]        data_writeReg,
   input  logic [NUM_RD*ADDR_W-1:0] ctrl_readReg,
   output logic [NUM_RD*DATA_W-1:0] data_readReg,
   input  logic                     ctrl_clear,
   output logic                     clear_busy,
   output logic                     clear_done,
   output logic                     write_drop
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              r_drop;
   logic              w_sweep_we;
   logic [ADDR_W-1:0] w_idx;
   logic              w_wr_req;
   logic              w_wr_ok;

   regfile_clear_fsm #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clear_fsm (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .i_clear    (ctrl_clear),
      .o_busy     (clear_busy),
      .o_done     (clear_done),
      .o_sweep_we (w_sweep_we),
      .o_idx      (w_idx)
   );

   // A write colliding with a sweep, or with the cycle that launches one, is lost.
   assign w_wr_req = ctrl_writeEnable && (ctrl_writeReg != '0);
   assign w_wr_ok  = w_wr_req && !clear_busy && !ctrl_clear;

   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_sweep_we) begin
         r_mem[w_idx] <= '0;
      end else if (w_wr_ok) begin
         r_mem[ctrl_writeReg] <= data_writeReg;
      end
   end

   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) r_drop <= 1'b0;
      else             r_drop <= w_wr_req && !w_wr_ok;
   end

   assign write_drop = r_drop;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;

      assign w_ra = ctrl_readReg[k*ADDR_W +: ADDR_W];

      always_comb begin
         w_rd = r_mem[w_ra];
`ifdef REGFILE_BYPASS_EN
         if (w_wr_ok && (w_ra == ctrl_writeReg)) w_rd = data_writeReg;
`endif
         if (w_ra == '0) w_rd = '0;
      end

      assign data_readReg[k*DATA_W +: DATA_W] = w_rd;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table for write/read behaviour plus
// hand-written clear-sweep, dropped-write and reset-abort sequences.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        ctrl_reset;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [9:0]  ctrl_readReg;
   logic [63:0] data_readReg;
   logic        ctrl_clear;
   logic        clear_busy;
   logic        clear_done;
   logic        write_drop;

   logic [4:0]  ra0, ra1;
   logic [31:0] rd0, rd1;
   assign ctrl_readReg = {ra1, ra0};
   assign rd0 = data_readReg[31:0];
   assign rd1 = data_readReg[63:32];

   int n_chk  = 0;
   int n_fail = 0;

   regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) dut (
      .clock            (clock),
      .ctrl_reset       (ctrl_reset),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .ctrl_readReg     (ctrl_readReg),
      .data_readReg     (data_readReg),
      .ctrl_clear       (ctrl_clear),
      .clear_busy       (clear_busy),
      .clear_done       (clear_done),
      .write_drop       (write_drop)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic        edrop;
   } vec_t;

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'h0, 32'h0, 1'b0};
      vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0, 32'h0, 1'b0};
      vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
      vecs[3]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0, 32'hDEADBEEF, 1'b0};
      vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0, 1'b0};
      vecs[5]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd5,
                   BYP ? 32'hA5A5A5A5 : 32'h0, 32'hDEADBEEF, 1'b0};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
      vecs[7]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd1,
                   BYP ? 32'hFFFFFFFF : 32'h0, 32'h0, 1'b0};
      vecs[8]  = '{1'b1, 5'd1,  32'h00000001, 5'd31, 5'd7,  32'hFFFFFFFF, 32'hA5A5A5A5, 1'b0};
      vecs[9]  = '{1'b1, 5'd5,  32'h0,        5'd5,  5'd1,
                   BYP ? 32'h0 : 32'hDEADBEEF, 32'h1, 1'b0};
      vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h0, 32'hFFFFFFFF, 1'b0};

      ctrl_reset = 1'b0;
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg = '0;
      data_writeReg = '0;
      ctrl_clear = 1'b0;
      ra0 = 5'd0;
      ra1 = 5'd0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_busy", {31'b0, clear_busy}, 32'h0);
      chk("reset_done", {31'b0, clear_done}, 32'h0);
      chk("reset_drop", {31'b0, write_drop}, 32'h0);
      ctrl_reset = 1'b1;

      // table-driven write/read vectors
      for (int v = 0; v < 11; v++) begin
         ctrl_writeEnable = vecs[v].we;
         ctrl_writeReg    = vecs[v].wa;
         data_writeReg    = vecs[v].wd;
         ra0 = vecs[v].a0;
         ra1 = vecs[v].a1;
         #2;
         chk($sformatf("vec%0d_rd0", v), rd0, vecs[v].e0);
         chk($sformatf("vec%0d_rd1", v), rd1, vecs[v].e1);
         tick();
         chk($sformatf("vec%0d_drop", v), {31'b0, write_drop}, {31'b0, vecs[v].edrop});
      end
      ctrl_writeEnable = 1'b0;

      // fill r1..r31 with their index
      for (int i = 1; i < 32; i++) begin
         ctrl_writeEnable = 1'b1;
         ctrl_writeReg = 5'(i);
         data_writeReg = 32'(i);
         tick();
      end
      ctrl_writeEnable = 1'b0;
      ra0 = 5'd17;
      ra1 = 5'd31;
      #1;
      chk("fill_r17", rd0, 32'd17);
      chk("fill_r31", rd1, 32'd31);

      // launch clear together with a write that must be dropped
      ctrl_clear = 1'b1;
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg = 5'd9;
      data_writeReg = 32'h99;
      #1;
      chk("clr_launch_busy", {31'b0, clear_busy}, 32'h0);
      tick();
      ctrl_clear = 1'b0;
      ctrl_writeEnable = 1'b0;
      chk("clr_launch_drop", {31'b0, write_drop}, 32'h1);
      for (int n = 1; n <= 32; n++) begin
         chk($sformatf("sweep%0d_busy", n), {31'b0, clear_busy}, 32'h1);
         chk($sformatf("sweep%0d_done", n), {31'b0, clear_done}, (n == 32) ? 32'h1 : 32'h0);
         if (n == 2) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg = 5'd3;
            data_writeReg = 32'h33;
            ctrl_clear = 1'b1;
         end
         if (n == 3) begin
            ctrl_writeEnable = 1'b0;
            ctrl_clear = 1'b0;
            chk("sweep_wr_drop", {31'b0, write_drop}, 32'h1);
         end
         if (n == 4) chk("sweep_drop_clear", {31'b0, write_drop}, 32'h0);
         if (n == 5) begin
            ra0 = 5'd2;
            ra1 = 5'd20;
            #1;
            chk("sweep_r2_zeroed", rd0, 32'h0);
            chk("sweep_r20_intact", rd1, 32'd20);
         end
         tick();
      end
      chk("post_sweep_busy", {31'b0, clear_busy}, 32'h0);
      chk("post_sweep_done", {31'b0, clear_done}, 32'h0);
      for (int i = 0; i < 32; i++) begin
         ra0 = 5'(i);
         ra1 = 5'(31 - i);
         #1;
         chk($sformatf("cleared_r%0d_p0", i), rd0, 32'h0);
         chk($sformatf("cleared_r%0d_p1", 31 - i), rd1, 32'h0);
      end

      // reset asserted mid-sweep aborts it
      @(posedge clock);
      #1;
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg = 5'd4;
      data_writeReg = 32'h44;
      tick();
      ctrl_writeReg = 5'd30;
      data_writeReg = 32'h30;
      tick();
      ctrl_writeEnable = 1'b0;
      ctrl_clear = 1'b1;
      tick();
      ctrl_clear = 1'b0;
      repeat (9) tick();
      chk("abort_busy_before", {31'b0, clear_busy}, 32'h1);
      #2;
      ctrl_reset = 1'b0;
      #1;
      chk("abort_busy", {31'b0, clear_busy}, 32'h0);
      chk("abort_done", {31'b0, clear_done}, 32'h0);
      ra0 = 5'd4;
      ra1 = 5'd30;
      #1;
      chk("abort_r4", rd0, 32'h0);
      chk("abort_r30", rd1, 32'h0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("abort_hold%0d_done", c), {31'b0, clear_done}, 32'h0);
         chk($sformatf("abort_hold%0d_busy", c), {31'b0, clear_busy}, 32'h0);
      end

      // first edge after reset release accepts a write
      ctrl_reset = 1'b1;
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg = 5'd6;
      data_writeReg = 32'h66;
      ra0 = 5'd6;
      ra1 = 5'd6;
      tick();
      ctrl_writeEnable = 1'b0;
      #1;
      chk("post_reset_wr_p0", rd0, 32'h66);
      chk("post_reset_wr_p1", rd1, 32'h66);
      chk("post_reset_drop", {31'b0, write_drop}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
